// File: rtl/fpu_if_pkg.sv
// Shared types and widths for the core-side FPU issue/result path.
package fpu_if_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned WBK_W     = 2;

  localparam logic [WBK_W-1:0] WB_NONE = 2'd0;
  localparam logic [WBK_W-1:0] WB_GPR  = 2'd1;
  localparam logic [WBK_W-1:0] WB_FCC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

endpackage

// File: rtl/fpu_requester_if.sv
// Decode request, FPU issue/result and writeback signals seen by fpu_requester.
interface fpu_requester_if;
  import fpu_if_pkg::*;

  logic                 req_valid;
  logic                 req_accept;
  logic [OP_W-1:0]      req_op;
  logic [REG_IDX_W-1:0] req_fs;
  logic [REG_IDX_W-1:0] req_ft;
  logic [REG_IDX_W-1:0] req_fd;
  logic [DATA_W-1:0]    req_gpr_data;
  logic [WBK_W-1:0]     req_wb_kind;
  logic [REG_IDX_W-1:0] req_rd;

  logic [REG_IDX_W-1:0] fpu_x1;
  logic [REG_IDX_W-1:0] fpu_x2;
  logic [REG_IDX_W-1:0] fpu_y;
  logic [OP_W-1:0]      fpu_operation;
  logic [DATA_W-1:0]    fpu_in_data;
  logic                 fpu_ready;
  logic                 fpu_valid;
  logic                 fpu_out_data1;
  logic [DATA_W-1:0]    fpu_out_data32;

  logic                 gpr_we;
  logic [REG_IDX_W-1:0] gpr_waddr;
  logic [DATA_W-1:0]    gpr_wdata;
  logic                 fcc_we;
  logic                 fcc_wdata;
  logic                 busy;
  logic                 err_timeout;

  modport master (
    input  req_valid, req_op, req_fs, req_ft, req_fd, req_gpr_data, req_wb_kind, req_rd,
    input  fpu_valid, fpu_out_data1, fpu_out_data32,
    output req_accept, fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready,
    output gpr_we, gpr_waddr, gpr_wdata, fcc_we, fcc_wdata, busy, err_timeout
  );

  modport slave (
    output req_valid, req_op, req_fs, req_ft, req_fd, req_gpr_data, req_wb_kind, req_rd,
    output fpu_valid, fpu_out_data1, fpu_out_data32,
    input  req_accept, fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready,
    input  gpr_we, gpr_waddr, gpr_wdata, fcc_we, fcc_wdata, busy, err_timeout
  );

endinterface

// File: rtl/fpu_requester.sv
// Issues one FP instruction at a time to the FPU, waits for completion with a
// timeout, then writes the result to the GPR file or the FP condition flag.
module fpu_requester
  import fpu_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst,
  fpu_requester_if.master bus
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WBK_W-1:0]     r_wb_kind;
  logic [REG_IDX_W-1:0] r_rd;

  logic                 r_accept;
  logic [REG_IDX_W-1:0] r_x1;
  logic [REG_IDX_W-1:0] r_x2;
  logic [REG_IDX_W-1:0] r_y;
  logic [OP_W-1:0]      r_op;
  logic [DATA_W-1:0]    r_in_data;
  logic                 r_fpu_ready;
  logic                 r_gpr_we;
  logic [REG_IDX_W-1:0] r_gpr_waddr;
  logic [DATA_W-1:0]    r_gpr_wdata;
  logic                 r_fcc_we;
  logic                 r_fcc_wdata;
  logic                 r_busy;
  logic                 r_err_timeout;

  logic w_xfer;
  assign w_xfer = bus.req_valid & r_accept;

  // Writeback enables are raised on the WAIT->WB edge so they are live exactly during WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_wb_kind     <= WB_NONE;
      r_rd          <= '0;
      r_accept      <= 1'b0;
      r_x1          <= '0;
      r_x2          <= '0;
      r_y           <= '0;
      r_op          <= '0;
      r_in_data     <= '0;
      r_fpu_ready   <= 1'b0;
      r_gpr_we      <= 1'b0;
      r_gpr_waddr   <= '0;
      r_gpr_wdata   <= '0;
      r_fcc_we      <= 1'b0;
      r_fcc_wdata   <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_fpu_ready <= 1'b0;
      r_gpr_we    <= 1'b0;
      r_fcc_we    <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_x1        <= bus.req_fs;
            r_x2        <= bus.req_ft;
            r_y         <= bus.req_fd;
            r_op        <= bus.req_op;
            r_in_data   <= bus.req_gpr_data;
            r_wb_kind   <= bus.req_wb_kind;
            r_rd        <= bus.req_rd;
            r_fpu_ready <= 1'b1;
            r_busy      <= 1'b1;
            r_accept    <= 1'b0;
            r_state     <= ST_ISSUE;
          end else begin
            r_accept <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.fpu_valid) begin
            r_state <= ST_WB;
            if (r_wb_kind == WB_GPR) begin
              r_gpr_we    <= 1'b1;
              r_gpr_waddr <= r_rd;
              r_gpr_wdata <= bus.fpu_out_data32;
            end else if (r_wb_kind == WB_FCC) begin
              r_fcc_we    <= 1'b1;
              r_fcc_wdata <= bus.fpu_out_data1;
            end
          end else if (r_cnt == TERM_CNT) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_accept      <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_WB: begin
          r_busy   <= 1'b0;
          r_accept <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_accept    = r_accept;
  assign bus.fpu_x1        = r_x1;
  assign bus.fpu_x2        = r_x2;
  assign bus.fpu_y         = r_y;
  assign bus.fpu_operation = r_op;
  assign bus.fpu_in_data   = r_in_data;
  assign bus.fpu_ready     = r_fpu_ready;
  assign bus.gpr_we        = r_gpr_we;
  assign bus.gpr_waddr     = r_gpr_waddr;
  assign bus.gpr_wdata     = r_gpr_wdata;
  assign bus.fcc_we        = r_fcc_we;
  assign bus.fcc_wdata     = r_fcc_wdata;
  assign bus.busy          = r_busy;
  assign bus.err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_fpu_requester.sv
// Self-checking bench: table of FP ops with an FPU latency model and a writeback
// scoreboard, plus reset-mid-WAIT and timeout sequences.
module tb_fpu_requester;
  import fpu_if_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  fpu_requester_if bus ();
  fpu_requester_if bus2 ();

  fpu_requester #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fpu_requester #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_to (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.master)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  fs, ft, fd;
    logic [31:0] gdata;
    logic [1:0]  kind;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] r32;
    logic        r1;
    bit          spur;
    bit          chain;
    logic        exp_gwe;
    logic        exp_fwe;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_fdata;
  } vec_t;

  typedef struct {
    logic        gwe;
    logic        fwe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        fdata;
  } wb_t;

  int   n_assert = 0;
  int   n_fail   = 0;
  wb_t  sb_q[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] fs, input logic [4:0] ft,
                              input logic [4:0] fd, input logic [31:0] gdata, input logic [1:0] kind,
                              input logic [4:0] rd, input int lat, input logic [31:0] r32,
                              input logic r1, input bit spur, input bit chain, input logic egwe,
                              input logic efwe, input logic [4:0] ewaddr, input logic [31:0] ewdata,
                              input logic efdata);
    vec_t v;
    v.op = op; v.fs = fs; v.ft = ft; v.fd = fd; v.gdata = gdata; v.kind = kind; v.rd = rd;
    v.lat = lat; v.r32 = r32; v.r1 = r1; v.spur = spur; v.chain = chain;
    v.exp_gwe = egwe; v.exp_fwe = efwe; v.exp_waddr = ewaddr; v.exp_wdata = ewdata;
    v.exp_fdata = efdata;
    return v;
  endfunction

  // Drives one op starting at a negedge where req_accept is expected high.
  task automatic run_vec(input int i);
    vec_t v;
    wb_t  e;
    wb_t  got;
    v = vecs[i];
    chk($sformatf("v%0d accept_idle", i), 32'(bus.req_accept), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_op       = v.op;
    bus.req_fs       = v.fs;
    bus.req_ft       = v.ft;
    bus.req_fd       = v.fd;
    bus.req_gpr_data = v.gdata;
    bus.req_wb_kind  = v.kind;
    bus.req_rd       = v.rd;
    if (v.exp_gwe || v.exp_fwe) begin
      e.gwe = v.exp_gwe; e.fwe = v.exp_fwe; e.waddr = v.exp_waddr;
      e.wdata = v.exp_wdata; e.fdata = v.exp_fdata;
      sb_q.push_back(e);
    end
    @(posedge clk);
    for (int k = 1; k <= 3 + v.lat; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d k%0d fpu_ready", i, k), 32'(bus.fpu_ready), 32'(k == 1));
      chk($sformatf("v%0d k%0d busy", i, k), 32'(bus.busy), 32'(k <= 2 + v.lat));
      chk($sformatf("v%0d k%0d req_accept", i, k), 32'(bus.req_accept), 32'(k == 3 + v.lat));
      if (k == 1 || k == 1 + v.lat) begin
        chk($sformatf("v%0d k%0d fpu_x1", i, k), 32'(bus.fpu_x1), 32'(v.fs));
        chk($sformatf("v%0d k%0d fpu_x2", i, k), 32'(bus.fpu_x2), 32'(v.ft));
        chk($sformatf("v%0d k%0d fpu_y", i, k), 32'(bus.fpu_y), 32'(v.fd));
        chk($sformatf("v%0d k%0d fpu_op", i, k), 32'(bus.fpu_operation), 32'(v.op));
        chk($sformatf("v%0d k%0d fpu_in_data", i, k), bus.fpu_in_data, v.gdata);
      end
      if (bus.gpr_we || bus.fcc_we) begin
        if (sb_q.size() == 0 || k != 2 + v.lat) begin
          chk($sformatf("v%0d k%0d unexpected_wb", i, k), 32'(bus.gpr_we | bus.fcc_we), 32'd0);
        end else begin
          e = sb_q.pop_front();
          got.gwe = bus.gpr_we; got.fwe = bus.fcc_we;
          chk($sformatf("v%0d gpr_we", i), 32'(got.gwe), 32'(e.gwe));
          chk($sformatf("v%0d fcc_we", i), 32'(got.fwe), 32'(e.fwe));
          if (e.gwe) begin
            chk($sformatf("v%0d gpr_waddr", i), 32'(bus.gpr_waddr), 32'(e.waddr));
            chk($sformatf("v%0d gpr_wdata", i), bus.gpr_wdata, e.wdata);
          end
          if (e.fwe) chk($sformatf("v%0d fcc_wdata", i), 32'(bus.fcc_wdata), 32'(e.fdata));
        end
      end else if (k == 2 + v.lat && (v.exp_gwe || v.exp_fwe)) begin
        chk($sformatf("v%0d missing_wb", i), 32'(bus.gpr_we | bus.fcc_we), 32'd1);
      end
      if (k == 1 && !v.chain) bus.req_valid = 1'b0;
      bus.fpu_valid      = (k == 1 + v.lat) || (k == 1 && v.spur);
      bus.fpu_out_data32 = (k == 1 + v.lat) ? v.r32 : 32'hBAD0_BAD0;
      bus.fpu_out_data1  = (k == 1 + v.lat) ? v.r1 : ~v.r1;
    end
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    {bus.req_valid, bus.req_op, bus.req_fs, bus.req_ft, bus.req_fd} = '0;
    {bus.req_gpr_data, bus.req_wb_kind, bus.req_rd} = '0;
    {bus.fpu_valid, bus.fpu_out_data1, bus.fpu_out_data32} = '0;
    {bus2.req_valid, bus2.req_op, bus2.req_fs, bus2.req_ft, bus2.req_fd} = '0;
    {bus2.req_gpr_data, bus2.req_wb_kind, bus2.req_rd} = '0;
    {bus2.fpu_valid, bus2.fpu_out_data1, bus2.fpu_out_data32} = '0;

    //        op     fs  ft  fd  gdata          kind rd  L  r32            r1 sp ch gwe fwe wa  wdata          fd
    vecs[0] = mk(6'h01, 3,  4,  5,  32'h0000_0000, 2'd0, 0,  3, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0,  32'h0,         0);
    vecs[1] = mk(6'h02, 1,  2,  3,  32'h1111_2222, 2'd1, 7,  1, 32'h3F80_0000, 0, 0, 0, 1, 0, 7,  32'h3F80_0000, 0);
    vecs[2] = mk(6'h03, 6,  7,  8,  32'h0000_0001, 2'd2, 9,  5, 32'h0000_0000, 1, 0, 0, 0, 1, 0,  32'h0,         1);
    vecs[3] = mk(6'h3F, 31, 30, 29, 32'hFFFF_FFFF, 2'd3, 4,  2, 32'h5555_5555, 1, 0, 0, 0, 0, 0,  32'h0,         0);
    vecs[4] = mk(6'h10, 0,  0,  0,  32'h8000_0000, 2'd1, 0,  2, 32'h1234_5678, 0, 0, 0, 1, 0, 0,  32'h1234_5678, 0);
    vecs[5] = mk(6'h21, 12, 13, 14, 32'hA5A5_A5A5, 2'd1, 10, 2, 32'hCAFE_F00D, 0, 1, 1, 1, 0, 10, 32'hCAFE_F00D, 0);
    vecs[6] = mk(6'h22, 15, 16, 17, 32'h5A5A_5A5A, 2'd2, 3,  1, 32'h0BAD_CAFE, 0, 1, 0, 0, 1, 0,  32'h0,         0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst fpu_ready", 32'(bus.fpu_ready), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst req_accept", 32'(bus.req_accept), 32'd0);
    chk("rst err_timeout", 32'(bus.err_timeout), 32'd0);
    chk("rst gpr_we", 32'(bus.gpr_we), 32'd0);
    chk("rst fpu_x1", 32'(bus.fpu_x1), 32'd0);
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("err_timeout_clean", 32'(bus.err_timeout), 32'd0);

    // Reset while waiting on the FPU: no writeback may follow.
    bus.req_valid = 1'b1; bus.req_wb_kind = WB_GPR; bus.req_rd = 5'd11; bus.req_fs = 5'd9;
    bus.req_gpr_data = 32'h7777_0000;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst fpu_ready", 32'(bus.fpu_ready), 32'd0);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst req_accept", 32'(bus.req_accept), 32'd0);
    chk("midrst fpu_x1", 32'(bus.fpu_x1), 32'd0);
    chk("midrst fpu_in_data", bus.fpu_in_data, 32'd0);
    chk("midrst gpr_we", 32'(bus.gpr_we), 32'd0);
    rst = 1'b0;
    bus.fpu_valid = 1'b1; bus.fpu_out_data32 = 32'h0123_4567; bus.fpu_out_data1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.fpu_valid = 1'b0;
      chk($sformatf("postrst k%0d gpr_we", k), 32'(bus.gpr_we), 32'd0);
      chk($sformatf("postrst k%0d fcc_we", k), 32'(bus.fcc_we), 32'd0);
      chk($sformatf("postrst k%0d busy", k), 32'(bus.busy), 32'd0);
    end
    chk("postrst req_accept", 32'(bus.req_accept), 32'd1);

    // Timeout with TIMEOUT_CYCLES=4: FPU never answers; a late valid is ignored.
    chk("to accept_idle", 32'(bus2.req_accept), 32'd1);
    bus2.req_valid = 1'b1; bus2.req_wb_kind = WB_GPR; bus2.req_rd = 5'd9; bus2.req_op = 6'h05;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus2.req_valid = 1'b0;
      chk($sformatf("to k%0d busy", k), 32'(bus2.busy), 32'(k <= 5));
      chk($sformatf("to k%0d err_timeout", k), 32'(bus2.err_timeout), 32'(k >= 6));
      chk($sformatf("to k%0d gpr_we", k), 32'(bus2.gpr_we), 32'd0);
      chk($sformatf("to k%0d fcc_we", k), 32'(bus2.fcc_we), 32'd0);
      if (k == 6) chk("to accept_back", 32'(bus2.req_accept), 32'd1);
      bus2.fpu_valid = (k == 6);
      bus2.fpu_out_data32 = 32'hFEED_FACE;
    end
    rst2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("to err_cleared", 32'(bus2.err_timeout), 32'd0);
    rst2 = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_requester.md
Name: fpu_requester

Overview:
- Core-side initiator for the FPU issue/result interface.
- Accepts one decoded floating-point instruction at a time from the CPU decode stage and drives the FPU's operand-index, operation and integer-data lines with a one-cycle start strobe.
- Waits for the FPU's completion strobe, then routes the result to the integer register file (32-bit) or to the FP condition flag (1-bit).
- Drives the pipeline stall and flags FPU timeouts.

Parameters:
- TIMEOUT_CYCLES, 64: cycles allowed in WAIT before abort; legal range is 2..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  decode presents an FP instruction.
- req_accept  output  1  high only in IDLE; a transfer happens when req_valid & req_accept.
- req_op  input  6  FPU operation code.
- req_fs  input  5  FP source register 1 index.
- req_ft  input  5  FP source register 2 index.
- req_fd  input  5  FP destination register index.
- req_gpr_data  input  32  integer operand (int-to-FP moves).
- req_wb_kind  input  2  0=none, 1=GPR, 2=FCC, 3=reserved (treated as none).
- req_rd  input  5  GPR destination index for wb_kind=1.
- fpu_x1  output  5  to FPU source 1.
- fpu_x2  output  5  to FPU source 2.
- fpu_y  output  5  to FPU destination.
- fpu_operation  output  6  to FPU operation.
- fpu_in_data  output  32  to FPU integer data input.
- fpu_ready  output  1  one-cycle start strobe to the FPU.
- fpu_valid  input  1  FPU completion strobe.
- fpu_out_data1  input  1  FPU compare result.
- fpu_out_data32  input  32  FPU 32-bit result.
- gpr_we  output  1  one-cycle GPR write enable.
- gpr_waddr  output  5  GPR write address.
- gpr_wdata  output  32  GPR write data.
- fcc_we  output  1  one-cycle condition-flag write enable.
- fcc_wdata  output  1  condition-flag write value.
- busy  output  1  stall request to the pipeline; high in every state except IDLE.
- err_timeout  output  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset: every output register is 0, the FSM enters IDLE, the counter is 0, err_timeout is 0. Because rst is synchronous, asserting it mid-operation aborts at the next edge with no writeback. A late fpu_valid after reset is ignored because the FSM is in IDLE.
- FSM states: IDLE -> ISSUE -> WAIT -> WB -> IDLE.
- IDLE: req_accept=1, busy=0. On a transfer, latch op, fs, ft, fd, gpr_data, wb_kind and rd into the fpu_* and internal registers, then go to ISSUE.
- ISSUE (one cycle): fpu_ready=1, counter cleared. Always go to WAIT. An fpu_valid seen in this cycle is ignored.
- WAIT:
  - fpu_ready=0; fpu_x1/x2/y/operation/in_data stay stable; counter increments each cycle.
  - If fpu_valid=1, capture fpu_out_data32 and fpu_out_data1 and go to WB.
  - Else if counter == TIMEOUT_CYCLES-1, set err_timeout and go to IDLE with no writeback.
  - fpu_valid in the same cycle as the terminal count: valid wins and the operation completes.
- WB (one cycle):
  - wb_kind=1: gpr_we=1, gpr_waddr=rd, gpr_wdata=captured 32-bit result.
  - wb_kind=2: fcc_we=1, fcc_wdata=captured 1-bit result.
  - Otherwise no enable is raised.
  - Writes to GPR 0 are issued unchanged; the register file discards them.
  - Go to IDLE.
- Latency: transfer at cycle T; fpu_ready at T+1; for an FPU latency of L cycles after the strobe (L>=1), fpu_valid arrives at T+1+L and the write enable at T+2+L. busy is high from T+1 through T+2+L.
- Throughput: one instruction outstanding. req_accept is low in ISSUE, WAIT and WB. The next transfer is possible at T+3+L.
- fpu_valid outside WAIT is ignored in all cases.
- fpu_* outputs hold their last values in IDLE; they are not zeroed.

Decomposition:
- Shared package fpu_if_pkg:
  - State encoding enum (IDLE, ISSUE, WAIT, WB).
  - wb_kind constants WB_NONE, WB_GPR, WB_FCC.
  - Width constants: REG_IDX_W=5, OP_W=6, DATA_W=32.
- No sub-module. The FSM, counter and capture registers live in one module.

Test Plan:
- Reset then one op: op=6'h01, fs=3, ft=4, fd=5, wb_kind=0; FPU model with L=3 -> fpu_ready high exactly at T+1 with x1=3, x2=4, y=5; busy high T+1..T+5; no write enables; req_accept back at T+6.
- GPR writeback: wb_kind=1, rd=7, FPU returns out_data32=32'h3F800000 at L=1 -> gpr_we=1, waddr=7, wdata=32'h3F800000 for exactly one cycle at T+3.
- FCC writeback: wb_kind=2, FPU returns out_data1=1 at L=5 -> fcc_we=1, fcc_wdata=1 at T+7; gpr_we stays 0.
- Timeout: TIMEOUT_CYCLES=4 and the FPU never responds -> err_timeout rises after 4 WAIT cycles, FSM returns to IDLE with no writeback; a later fpu_valid is ignored; err_timeout holds until rst.
- Reset mid-WAIT: rst at T+2 -> all outputs 0 next cycle; a subsequent fpu_valid produces no gpr_we or fcc_we.
- Back-to-back plus spurious valid: req_valid held high for two ops, fpu_valid pulsed during ISSUE -> second op accepted only at T+3+L, spurious valid ignored, two correct writebacks.
